// File: rtl/matrix_mult_slave_if.sv
// Bus between the matrix bus master and the matrix-multiply slave.
// Handshake: there is no valid/ready pair. An access is valid when S_sel=1
// and S_address[7:4] matches the slave BASE. A valid write (S_wr=1) commits
// on the rising clock edge; a valid read (S_wr=0) returns data on S_dout
// combinationally in the same cycle. S_dout is 0 whenever no valid read is
// in progress.
interface matrix_mult_slave_if #(
  parameter int W = 32
);
  logic         S_sel;
  logic         S_wr;
  logic [7:0]   S_address;
  logic [W-1:0] S_din;
  logic [W-1:0] S_dout;

  modport master (output S_sel, output S_wr, output S_address, output S_din, input S_dout);
  modport slave  (input S_sel, input S_wr, input S_address, input S_din, output S_dout);
endinterface

// File: rtl/matrix_mult_slave.sv
// 2x2 matrix multiply slave: holds A and B, computes C = A x B with one
// multiply-accumulate per cycle over 8 cycles, and raises m_interrupt on done.
module matrix_mult_slave #(
  parameter logic [3:0] BASE = 4'h6,
  parameter int         W    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  matrix_mult_slave_if.slave  bus,
  output logic                m_interrupt,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [2:0]   count;
  logic [W-1:0] acc;
  logic [W-1:0] a_reg [4];
  logic [W-1:0] b_reg [4];
  logic [W-1:0] c_reg [4];

  logic         hit;
  logic         wr_en;
  logic         rd_en;
  logic [3:0]   offset;
  logic         ctrl_wr;
  logic         start_cmd;
  logic         clear_cmd;
  logic [1:0]   a_idx;
  logic [1:0]   b_idx;
  logic [1:0]   c_idx;
  logic [W-1:0] prod;

  assign offset    = bus.S_address[3:0];
  assign hit       = bus.S_sel && (bus.S_address[7:4] == BASE);
  assign wr_en     = hit && bus.S_wr;
  assign rd_en     = hit && !bus.S_wr;
  assign ctrl_wr   = wr_en && (offset == 4'hC);
  assign clear_cmd = ctrl_wr && bus.S_din[1];
  assign start_cmd = ctrl_wr && bus.S_din[0];

  // count = {i, j, t}: A[i][t] sits at index {i,t}, B[t][j] at {t,j}, C[i][j] at {i,j}
  assign a_idx = {count[2], count[0]};
  assign b_idx = {count[0], count[1]};
  assign c_idx = {count[2], count[1]};
  assign prod  = a_reg[a_idx] * b_reg[b_idx];

  assign m_interrupt = (state == DONE);
  assign dbg_state   = state;

  // Operand registers; locked while a computation is running
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        a_reg[i] <= '0;
        b_reg[i] <= '0;
      end
    end else if (wr_en && (state != EXEC)) begin
      if (offset[3:2] == 2'b00) a_reg[offset[1:0]] <= bus.S_din;
      if (offset[3:2] == 2'b01) b_reg[offset[1:0]] <= bus.S_din;
    end
  end

  // Control FSM and multiply-accumulate datapath; clear beats start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      acc   <= '0;
      for (int i = 0; i < 4; i++) c_reg[i] <= '0;
    end else if (clear_cmd) begin
      state <= IDLE;
      count <= '0;
      acc   <= '0;
      for (int i = 0; i < 4; i++) c_reg[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_cmd) begin
            state <= EXEC;
            count <= '0;
            acc   <= '0;
          end
        end
        EXEC: begin
          if (count[0] == 1'b0) acc <= prod;
          else                  c_reg[c_idx] <= acc + prod;
          count <= count + 3'd1;
          if (count == 3'd7) state <= DONE;
        end
        default: begin
          state <= IDLE;
          count <= '0;
          acc   <= '0;
        end
      endcase
    end
  end

  // Read mux; returns 0 for writes, misses, control and reserved offsets
  always_comb begin
    bus.S_dout = '0;
    if (rd_en) begin
      case (offset[3:2])
        2'b00: bus.S_dout = a_reg[offset[1:0]];
        2'b01: bus.S_dout = b_reg[offset[1:0]];
        2'b10: bus.S_dout = c_reg[offset[1:0]];
        default: begin
          if (offset == 4'hD) begin
            bus.S_dout[0] = (state == EXEC);
            bus.S_dout[1] = (state == DONE);
          end
        end
      endcase
    end
  end

endmodule
